// File: rtl/rr_arbiter_4_onehot_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The requester side uses the master modport; the arbiter uses slave.
interface rr_arbiter_4_onehot_if;
    // Handshake: a requester holds i_req[i] high until it has finished with the
    // resource. Ownership runs from the registered o_grant[i] rising until the
    // owner pulses i_release, drops i_req[i], or (if enabled) o_timeout fires.
    logic [3:0] i_req;
    logic       i_release;
    logic [3:0] o_grant;
    logic [1:0] o_grant_idx;
    logic       o_grant_valid;
    logic       o_timeout;
    logic       o_dbg_state;

    modport master (
        output i_req, i_release,
        input  o_grant, o_grant_idx, o_grant_valid, o_timeout, o_dbg_state
    );

    modport slave (
        input  i_req, i_release,
        output o_grant, o_grant_idx, o_grant_valid, o_timeout, o_dbg_state
    );
endinterface

// File: rtl/rr_arbiter_4_onehot.sv
// Four-way round-robin arbiter with registered one-hot grant and encoded owner.
// Define ARB_TIMEOUT_EN to revoke a grant held for MAX_HOLD cycles.
module rr_arbiter_4_onehot #(
    parameter int unsigned MAX_HOLD = 16
) (
    input logic                  clk,
    input logic                  rst,
    rr_arbiter_4_onehot_if.slave bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_idx;
    logic [1:0] w_idx_nxt;
    logic [3:0] r_grant;
    logic [3:0] w_grant_nxt;
    logic       r_valid;
    logic [1:0] w_winner;
    logic       w_any_req;
    logic       w_timeout_nxt;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must lie in 1..255");
    end

    // Scan from the highest search offset down so the lowest offset wins.
    always_comb begin
        w_winner  = r_ptr;
        w_any_req = |bus.i_req;
        for (int k = 3; k >= 0; k--) begin
            if (bus.i_req[r_ptr + 2'(k)]) begin
                w_winner = r_ptr + 2'(k);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;
    logic       r_timeout;

    // Zero throughout IDLE, so it is already clear on the cycle a grant starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 8'd0;
        end else if (r_state == S_IDLE) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= r_hold + 8'd1;
        end
    end
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_idx_nxt     = r_idx;
        w_ptr_nxt     = r_ptr;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = 4'b0001 << w_winner;
                    w_idx_nxt   = w_winner;
                    w_ptr_nxt   = w_winner + 2'd1;
                end else begin
                    w_grant_nxt = 4'b0000;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_GRANT: begin
                if (bus.i_release || !bus.i_req[r_idx]) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = 4'b0000;
                    w_idx_nxt   = 2'd0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_hold == HOLD_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_grant_nxt   = 4'b0000;
                    w_idx_nxt     = 2'd0;
                    w_timeout_nxt = 1'b1;
                end
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = 4'b0000;
                w_idx_nxt   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 2'd0;
            r_idx   <= 2'd0;
            r_grant <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_idx   <= w_idx_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= |w_grant_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign bus.o_timeout = r_timeout;
`else
    logic w_unused;
    assign w_unused      = w_timeout_nxt;
    assign bus.o_timeout = 1'b0;
`endif

    assign bus.o_grant       = r_grant;
    assign bus.o_grant_idx   = r_idx;
    assign bus.o_grant_valid = r_valid;
    assign bus.o_dbg_state   = r_state;

endmodule

// File: tb/tb_rr_arbiter_4_onehot.sv
// Scoreboard bench for rr_arbiter_4_onehot: directed plan sequences plus random
// traffic checked against an owner/pointer reference model.
module tb_rr_arbiter_4_onehot;

    localparam int TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    rr_arbiter_4_onehot_if bus();

    rr_arbiter_4_onehot #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected entry layout: {timeout, valid, idx[1:0], grant[3:0]}
    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         tests = 0;
    int         failed = 0;

    // Reference model: current owner (-1 = none), next search start, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    function automatic logic [7:0] pack_exp(input logic [3:0] g, input logic to);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) idx = 2'(i);
        end
        return {to, (g != 4'b0000), idx, g};
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic rl, input logic rs);
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_hold  = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (m_owner < 0 && r[j]) m_owner = j;
            end
            if (m_owner >= 0) begin
                m_ptr  = (m_owner + 1) % 4;
                m_hold = 1;
            end
        end else if (rl || !r[m_owner]) begin
            m_owner = -1;
        end else if (TO_EN && m_hold == TB_MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_hold++;
        end
    endfunction

    function automatic logic [7:0] model_exp();
        logic [3:0] g;
        g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        return pack_exp(g, m_to);
    endfunction

    task automatic drive(input logic [3:0] r, input logic rl, input logic rs, input string tag,
                         input bit use_fixed, input logic [3:0] fg, input logic fto);
        logic [7:0] e;
        bus.i_req     = r;
        bus.i_release = rl;
        rst           = rs;
        model_step(r, rl, rs);
        e = use_fixed ? pack_exp(fg, fto) : model_exp();
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic stepf(input logic [3:0] r, input logic rl, input logic rs, input string tag,
                         input logic [3:0] fg, input logic fto);
        drive(r, rl, rs, tag, 1'b1, fg, fto);
    endtask

    task automatic stepm(input logic [3:0] r, input logic rl, input logic rs, input string tag);
        drive(r, rl, rs, tag, 1'b0, 4'b0000, 1'b0);
    endtask

    // Monitor: one registered output set per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [7:0] e;
            string      t;
            bit         ok;
            e  = exp_q.pop_front();
            t  = tag_q.pop_front();
            ok = (bus.o_grant == e[3:0]) && (bus.o_grant_valid == e[6]) &&
                 (bus.o_timeout == e[7]) && (!e[6] || bus.o_grant_idx == e[5:4]);
            tests++;
            if (!ok) begin
                failed++;
                $display("FAIL %s @%0t: got grant=%b idx=%0d valid=%b timeout=%b, expected grant=%b idx=%0d valid=%b timeout=%b",
                         t, $time, bus.o_grant, bus.o_grant_idx, bus.o_grant_valid, bus.o_timeout,
                         e[3:0], e[5:4], e[6], e[7]);
            end
        end
    end

    initial begin
        logic [3:0] rq;
        logic       rl;
        logic       rs;

        bus.i_req     = 4'b0000;
        bus.i_release = 1'b0;
        rst           = 1'b1;

        // Reset with all requests pending, then first grant to requester 0.
        stepf(4'b1111, 1'b0, 1'b1, "reset_0", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b1, "reset_1", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b0, "reset_first_grant", 4'b0001, 1'b0);

        // Fairness with one release per grant period.
        stepf(4'b1111, 1'b1, 1'b0, "fair_gap0", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b0, "fair_g1",   4'b0010, 1'b0);
        stepf(4'b1111, 1'b1, 1'b0, "fair_gap1", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b0, "fair_g2",   4'b0100, 1'b0);
        stepf(4'b1111, 1'b1, 1'b0, "fair_gap2", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b0, "fair_g3",   4'b1000, 1'b0);
        stepf(4'b1111, 1'b1, 1'b0, "fair_gap3", 4'b0000, 1'b0);
        stepf(4'b1111, 1'b0, 1'b0, "fair_g0",   4'b0001, 1'b0);

        // Single requester 3, pointer wraps to 0.
        stepf(4'b1000, 1'b1, 1'b0, "wrap_drop",    4'b0000, 1'b0);
        stepf(4'b1000, 1'b0, 1'b0, "wrap_g3",      4'b1000, 1'b0);
        stepf(4'b1000, 1'b0, 1'b0, "wrap_hold",    4'b1000, 1'b0);
        stepf(4'b1000, 1'b1, 1'b0, "wrap_release", 4'b0000, 1'b0);
        stepf(4'b1001, 1'b0, 1'b0, "wrap_g0",      4'b0001, 1'b0);

        // Owner 2 withdraws without release.
        stepf(4'b0100, 1'b1, 1'b0, "wd_drop",     4'b0000, 1'b0);
        stepf(4'b0100, 1'b0, 1'b0, "wd_g2",       4'b0100, 1'b0);
        stepf(4'b0100, 1'b0, 1'b0, "wd_hold",     4'b0100, 1'b0);
        stepf(4'b0010, 1'b0, 1'b0, "wd_withdraw", 4'b0000, 1'b0);
        stepf(4'b0010, 1'b0, 1'b0, "wd_g1",       4'b0010, 1'b0);

        // Reset while requester 1 owns; pointer returns to 0.
        stepf(4'b1110, 1'b0, 1'b1, "midrst_drop", 4'b0000, 1'b0);
        stepf(4'b1110, 1'b0, 1'b0, "midrst_g1",   4'b0010, 1'b0);

        // Long hold: forced revoke when enabled, indefinite hold otherwise.
        stepf(4'b0101, 1'b0, 1'b1, "hold_rst", 4'b0000, 1'b0);
        stepf(4'b0101, 1'b0, 1'b0, "hold_c1",  4'b0001, 1'b0);
        stepf(4'b0101, 1'b0, 1'b0, "hold_c2",  4'b0001, 1'b0);
        stepf(4'b0101, 1'b0, 1'b0, "hold_c3",  4'b0001, 1'b0);
        stepf(4'b0101, 1'b0, 1'b0, "hold_c4",  4'b0001, 1'b0);
`ifdef ARB_TIMEOUT_EN
        stepf(4'b0101, 1'b0, 1'b0, "to_pulse", 4'b0000, 1'b1);
        stepf(4'b0101, 1'b0, 1'b0, "to_next",  4'b0100, 1'b0);
`else
        stepf(4'b0101, 1'b0, 1'b0, "hold_c5",  4'b0001, 1'b0);
        stepf(4'b0101, 1'b0, 1'b0, "hold_c6",  4'b0001, 1'b0);
`endif
        stepf(4'b0101, 1'b1, 1'b0, "hold_release", 4'b0000, 1'b0);

        // Randomized traffic with sticky requests against the reference model.
        rq = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rl = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 80) == 0);
            stepm(rq, rl, rs, "random");
        end

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4_onehot.md
Name: rr_arbiter_4_onehot

Overview:
Round-robin arbiter that shares one resource between four requesters. It issues a registered one-hot grant, equivalent to a 2-to-4 decoder output gated by an enable, plus the encoded owner index. It sits between the request sources and the shared resource's select and enable inputs, and sequences ownership with a request/release handshake.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles before forced revoke; legal range 1..255; used only when ARB_TIMEOUT_EN is defined.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req  input  4  request per requester; bit i = requester i
release  input  1  current owner finished; sampled only in GRANT
grant  output  4  registered one-hot grant; all-zero when no owner
grant_idx  output  2  encoded owner index; valid only when grant_valid=1
grant_valid  output  1  1 when grant is non-zero
timeout  output  1  one-cycle pulse on forced revoke; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Clocking and reset:
  - Single clock domain; all outputs registered.
  - Reset is synchronous and active-high. While rst=1 at a clk edge: state=IDLE, grant=4'b0000, grant_idx=2'd0, grant_valid=0, timeout=0, rr pointer=2'd0, hold counter=0.
  - Reset mid-grant drops grant on the same edge. No partial state survives.
- State machine: states IDLE and GRANT.
  - IDLE: if req!=0, pick the winner, go to GRANT, and register grant/grant_idx/grant_valid=1 at that edge. If req==0, stay in IDLE with outputs zero.
  - GRANT: go to IDLE with grant=0 at the next edge when release=1 or req[grant_idx]=0 (requester withdrew). Otherwise hold the grant unchanged.
- Handover: ownership never moves directly between requesters. At least one IDLE cycle with grant=0 separates consecutive grants. Hand-over latency is release edge -> 1 idle cycle -> new grant.
- Latency: req asserted before edge N gives grant visible after edge N (1-cycle registered).
- Round-robin rule:
  - Search order starts at pointer p and wraps: p, p+1, p+2, p+3 (mod 4). First set req bit wins.
  - On each grant, p <= winner+1 (mod 4). A winner of 3 wraps p to 0.
- Simultaneous events:
  - release=1 with other reqs pending: still drop to IDLE first.
  - release=1 while not in GRANT: ignored.
  - Owner req stays high after release: the owner is re-eligible, but the pointer has moved past it, so other pending requesters win first.
- Invariants:
  - grant is always 0 or exactly one-hot.
  - grant==(4'b0001<<grant_idx) whenever grant_valid=1.
  - grant_valid==|grant.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 with no release, the next edge forces IDLE, drops grant, and pulses timeout=1 for exactly one cycle.
  - The pointer has already advanced past the owner.
  - release in the same cycle as the timeout: release wins, timeout stays 0.
- Not defined: no counter is present, grant is held indefinitely, and timeout is tied to 0.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=4'b1111 -> grant=0000, grant_valid=0, grant_idx=0, timeout=0. Deassert rst -> next edge grant=0001, grant_idx=0.
2. Fairness: req=4'b1111 held, release pulsed 1 cycle in every GRANT period -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
3. Single requester with wrap: req=4'b1000 only -> grant=1000, idx=3. After release, pointer=0. Then req=4'b1001 -> next grant=0001.
4. Withdrawal: owner 2 granted, req drops to 4'b0010 with no release -> grant=0000 next edge, then grant=0010 the following edge.
5. Mid-grant reset: owner 1 granted, rst=1 for 1 cycle with req=4'b1110 -> grant=0000 on that edge. After reset, pointer=0, so grant=0010 (idx 1, first set bit from 0).
6. (ARB_TIMEOUT_EN, MAX_HOLD=4): req=4'b0101, no release -> grant=0001 for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0000, then grant=0100.
